dac_frame_scheduler: RTL and testbench



---
 rtl/dac_pkg.sv | 24 ++
 rtl/dac_frame_shifter.sv | 46 ++++
 rtl/dac_frame_scheduler.sv | 96 +++++++++
 tb/tb_dac_frame_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// dac_pkg: shared widths, FSM state type and round-robin pick helper for the DAC frame scheduler
package dac_pkg;

    localparam int DAC_WORD_W  = 16;
    localparam int DAC_FRAME_W = 32;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} dac_state_t;

    // First valid index at or after ptr, wrapping modulo n (n <= 8)
    function automatic logic [2:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr, input int n);
        logic found;
        int   j;
        rr_pick = '0;
        found   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            j = (int'(ptr) + k) % n;
            if (k < n && !found && valid[3'(j)]) begin
                rr_pick = 3'(j);
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/dac_frame_shifter.sv
// dac_frame_shifter: loads one frame and presents it MSB-first, one bit per clock, while busy
module dac_frame_shifter
    import dac_pkg::*;
#(
    parameter int FRAME_BITS = DAC_FRAME_W
) (
    input  logic                  DAC_CLK,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [FRAME_BITS-1:0] i_frame,
    output logic                  o_busy,
    output logic                  o_last_bit,
    output logic                  o_mosi
);

    localparam int CW = $clog2(FRAME_BITS);

    logic [FRAME_BITS-1:0] r_sr;
    logic [CW-1:0]         r_cnt;
    logic                  r_active;

    // Load on grant, then shift one bit per cycle until the last bit has been presented
    always_ff @(posedge DAC_CLK) begin
        if (reset) begin
            r_sr     <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_sr     <= i_frame;
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (o_last_bit) begin
                r_active <= 1'b0;
            end else begin
                r_sr  <= {r_sr[FRAME_BITS-2:0], 1'b0};
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_busy     = r_active;
    assign o_last_bit = r_active && (r_cnt == CW'(FRAME_BITS - 1));
    assign o_mosi     = r_active & r_sr[FRAME_BITS-1];

endmodule

// File: rtl/dac_frame_scheduler.sv
// dac_frame_scheduler: round-robin sharing of one SPI DAC link among NUM_REQ frame requesters
// Build option DAC_REQ0_PRIORITY_EN: requester 0 (safety shutdown) wins every idle arbitration.
module dac_frame_scheduler
    import dac_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 2,
    parameter int FRAME_BITS = DAC_FRAME_W
) (
    input  logic                          DAC_CLK,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [DAC_WORD_W*NUM_REQ-1:0] req_word1,
    input  logic [DAC_WORD_W*NUM_REQ-1:0] req_word2,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          SPI_MOSI,
    output logic                          DAC_CS,
    output logic                          DAC_SCK,
    output logic [2:0]                    grant_id,
    output logic                          busy,
    output logic                          frame_done
);

    localparam int GW = $clog2(GAP_CYCLES + 1);

    dac_state_t            r_state, w_next;
    logic [2:0]            r_rr_ptr, r_grant, w_rr, w_pick, w_ptr_next;
    logic [GW-1:0]         r_gap;
    logic                  w_grant, w_adv, w_gap_end, w_last, w_shift_busy;
    logic [FRAME_BITS-1:0] w_frame;

    assign w_rr = rr_pick(8'(req_valid), r_rr_ptr, NUM_REQ);

`ifdef DAC_REQ0_PRIORITY_EN
    assign w_pick = req_valid[0] ? 3'd0 : w_rr;
    assign w_adv  = (w_pick != 3'd0);
`else
    assign w_pick = w_rr;
    assign w_adv  = 1'b1;
`endif

    assign w_grant    = (r_state == IDLE) && (|req_valid);
    assign w_ptr_next = (int'(w_pick) == NUM_REQ - 1) ? 3'd0 : w_pick + 3'd1;
    assign w_frame    = {req_word1[w_pick*DAC_WORD_W +: DAC_WORD_W], req_word2[w_pick*DAC_WORD_W +: DAC_WORD_W]};
    assign w_gap_end  = (r_gap == GW'(GAP_CYCLES - 1));

    // FSM state register
    always_ff @(posedge DAC_CLK) begin
        r_state <= reset ? IDLE : w_next;
    end

    // Round-robin pointer, served requester and chip-select-high gap counter
    always_ff @(posedge DAC_CLK) begin
        if (reset) begin
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_gap    <= '0;
        end else begin
            if (w_grant) begin
                r_grant <= w_pick;
                if (w_adv) r_rr_ptr <= w_ptr_next;
            end
            r_gap <= (r_state == GAP) ? r_gap + 1'b1 : '0;
        end
    end

    // Next-state logic: grant, one load cycle, shift until last bit, then hold the gap
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_grant ? LOAD : IDLE;
            LOAD:    w_next = SHIFT;
            SHIFT:   w_next = w_last ? GAP : SHIFT;
            GAP:     w_next = w_gap_end ? IDLE : GAP;
            default: w_next = IDLE;
        endcase
    end

    dac_frame_shifter #(.FRAME_BITS(FRAME_BITS)) u_shifter (
        .DAC_CLK    (DAC_CLK),
        .reset      (reset),
        .i_load     (w_grant),
        .i_frame    (w_frame),
        .o_busy     (w_shift_busy),
        .o_last_bit (w_last),
        .o_mosi     (SPI_MOSI)
    );

    assign req_ready  = w_grant ? (NUM_REQ'(1) << w_pick) : '0;
    assign busy       = (r_state != IDLE);
    assign frame_done = (r_state == GAP) && (r_gap == '0);
    assign grant_id   = busy ? r_grant : 3'd0;
    assign DAC_CS     = ~w_shift_busy;
    assign DAC_SCK    = DAC_CLK;

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// tb_dac_frame_scheduler: vector table, corner-case sequences and a frame-level reference model
module tb_dac_frame_scheduler;

    localparam int N   = 4;
    localparam int GAP = 2;
    localparam int PER = 1 + 32 + GAP;

    logic          DAC_CLK = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [16*N-1:0] req_word1, req_word2;
    logic [N-1:0]  req_ready;
    logic          SPI_MOSI, DAC_CS, DAC_SCK, busy, frame_done;
    logic [2:0]    grant_id;

    logic          reset5;
    logic [N-1:0]  v5, ready5;
    logic [16*N-1:0] w1_5, w2_5;
    logic          mosi5, cs5, sck5, busy5, done5;
    logic [2:0]    gid5;

    dac_frame_scheduler #(.NUM_REQ(N), .GAP_CYCLES(GAP)) u_dut (
        .DAC_CLK(DAC_CLK), .reset(reset), .req_valid(req_valid), .req_word1(req_word1),
        .req_word2(req_word2), .req_ready(req_ready), .SPI_MOSI(SPI_MOSI), .DAC_CS(DAC_CS),
        .DAC_SCK(DAC_SCK), .grant_id(grant_id), .busy(busy), .frame_done(frame_done)
    );

    dac_frame_scheduler #(.NUM_REQ(N), .GAP_CYCLES(5)) u_dut5 (
        .DAC_CLK(DAC_CLK), .reset(reset5), .req_valid(v5), .req_word1(w1_5),
        .req_word2(w2_5), .req_ready(ready5), .SPI_MOSI(mosi5), .DAC_CS(cs5),
        .DAC_SCK(sck5), .grant_id(gid5), .busy(busy5), .frame_done(done5)
    );

    always #5 DAC_CLK = ~DAC_CLK;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  exp_ready;
        logic [2:0]  exp_gid;
        logic [31:0] exp_frame;
    } vec_t;

    vec_t tab[6];
    logic [15:0] d1[4] = '{16'hA5F0, 16'h1234, 16'hBEEF, 16'h8001};
    logic [15:0] d2[4] = '{16'h0F0F, 16'h5678, 16'hCAFE, 16'h7FFE};

    int g_idx[16];
    int g_at[16];
    int got, hi_min, hi_max;
    int exp_order[5];
    int exp_pri[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge DAC_CLK);
        reset = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge DAC_CLK);
        reset = 1'b0;
    endtask

    task automatic load_words();
        for (int i = 0; i < N; i++) begin
            req_word1[16*i +: 16] = d1[i];
            req_word2[16*i +: 16] = d2[i];
        end
    endtask

    // Sample 36 cycles starting with the current one: serial bits, CS-low length, grant id, done offset
    task automatic capture(output logic [31:0] bits, output int low, output logic [2:0] gid, output int done_k);
        bits = '0; low = 0; gid = '0; done_k = -1;
        for (int k = 0; k < 36; k++) begin
            if (k > 0) @(negedge DAC_CLK);
            #1;
            if (!DAC_CS) begin
                if (low == 0) gid = grant_id;
                bits = {bits[30:0], SPI_MOSI};
                low++;
            end
            if (frame_done && done_k < 0) done_k = k;
        end
    endtask

    // Record up to n grants within bound cycles, plus CS-high run lengths between frames
    task automatic collect(input int n, input int bound);
        int hi;
        bit seen_low;
        got = 0; hi = 0; seen_low = 0; hi_min = 1000; hi_max = 0;
        for (int c = 0; c < bound && got < n; c++) begin
            if (c > 0) @(negedge DAC_CLK);
            #1;
            if (req_ready != '0) begin
                for (int i = 0; i < N; i++) if (req_ready[i]) g_idx[got] = i;
                g_at[got] = c;
                got++;
            end
            if (!DAC_CS) begin
                if (seen_low && hi > 0) begin
                    if (hi < hi_min) hi_min = hi;
                    if (hi > hi_max) hi_max = hi;
                end
                hi = 0;
                seen_low = 1;
            end else begin
                hi++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] bits;
        logic [2:0]  gid;
        int low, done_k;
        bit seen2;

        reset = 1'b1; req_valid = '0; req_word1 = '0; req_word2 = '0;
        reset5 = 1'b1; v5 = '0; w1_5 = '0; w2_5 = '0;

        tab[0] = '{4'b0001, 4'b0001, 3'd0, 32'hA5F00F0F};
        tab[1] = '{4'b1000, 4'b1000, 3'd3, 32'h80017FFE};
        tab[2] = '{4'b0110, 4'b0010, 3'd1, 32'h12345678};
        tab[3] = '{4'b1100, 4'b0100, 3'd2, 32'hBEEFCAFE};
        tab[4] = '{4'b1111, 4'b0001, 3'd0, 32'hA5F00F0F};
        tab[5] = '{4'b0000, 4'b0000, 3'd0, 32'h0};
`ifdef DAC_REQ0_PRIORITY_EN
        exp_order = '{0, 0, 0, 0, 0};
        exp_pri   = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
        exp_pri   = '{0, 1, 0, 1};
`endif

        load_words();
        do_reset();
        #1;
        check("reset_outputs", {req_ready, DAC_CS, SPI_MOSI, busy, frame_done, grant_id},
              {4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0});

        // Table: single arbitration from reset pointer, then the served frame
        for (int r = 0; r < 6; r++) begin
            do_reset();
            req_valid = tab[r].valid;
            #1;
            check($sformatf("tbl%0d_ready", r), req_ready, tab[r].exp_ready);
            @(negedge DAC_CLK);
            req_valid = '0;
            if (tab[r].exp_ready == '0) begin
                #1;
                check($sformatf("tbl%0d_idle", r), {busy, DAC_CS}, 2'b01);
            end else begin
                capture(bits, low, gid, done_k);
                check($sformatf("tbl%0d_frame", r), bits, tab[r].exp_frame);
                check($sformatf("tbl%0d_cs_low", r), low, 32);
                check($sformatf("tbl%0d_gid", r), gid, tab[r].exp_gid);
                check($sformatf("tbl%0d_done_at", r), done_k, 32);
            end
        end

        // All four continuously valid
        do_reset();
        req_valid = 4'b1111;
        collect(5, 5 * PER + 10);
        check("rr_grants", got, 5);
        for (int i = 0; i < 5 && i < got; i++) check($sformatf("rr_order%0d", i), g_idx[i], exp_order[i]);
        for (int i = 1; i < 5 && i < got; i++) check($sformatf("rr_period%0d", i), g_at[i] - g_at[i-1], PER);
        check("rr_cs_high_min", hi_min, GAP + 1);
        check("rr_cs_high_max", hi_max, GAP + 1);

        // Reset during SHIFT bit 10, then arbitration restarts from requester 0
        do_reset();
        req_valid = 4'b0001;
        #1;
        check("rst_first_ready", req_ready, 4'b0001);
        @(negedge DAC_CLK);
        req_valid = '0;
        repeat (10) @(negedge DAC_CLK);
        #1;
        check("rst_in_shift", {busy, DAC_CS}, 2'b10);
        reset = 1'b1;
        @(negedge DAC_CLK);
        reset = 1'b0;
        #1;
        check("rst_abort", {DAC_CS, SPI_MOSI, busy}, 3'b100);
        req_valid = 4'b1001;
        #1;
        check("rst_ptr_cleared", req_ready, 4'b0001);
        @(negedge DAC_CLK);
        req_valid = '0;

        // Requester 2 pulses valid only while requester 1 is shifting
        do_reset();
        req_valid = 4'b0010;
        #1;
        check("drop_first_ready", req_ready, 4'b0010);
        seen2 = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge DAC_CLK);
            req_valid = (k >= 5 && k < 10) ? 4'b0100 : 4'b0000;
            #1;
            if (req_ready[2]) seen2 = 1;
        end
        check("drop_no_ready2", seen2, 0);
        check("drop_idle", busy, 0);

        // Requesters 0 and 1 held valid
        do_reset();
        req_valid = 4'b0011;
        collect(4, 4 * PER + 10);
        check("pri_grants", got, 4);
        for (int i = 0; i < 4 && i < got; i++) check($sformatf("pri_order%0d", i), g_idx[i], exp_pri[i]);

        // Random traffic against a frame-level model
        begin
            int gstart, gidx, ptr, rel, g, ngr;
            logic [31:0] gframe;
            logic [3:0]  last_ready, exp_ready;
            logic        exp_cs, exp_mosi, exp_busy, exp_done;
            logic [2:0]  exp_gid;
            do_reset();
            gstart = -1000; gidx = 0; ptr = 0; ngr = 0; gframe = '0; last_ready = '0;
            for (int c = 0; c < 2000; c++) begin
                if (c > 0) @(negedge DAC_CLK);
                for (int i = 0; i < N; i++) begin
                    if (req_valid[i] && last_ready[i]) begin
                        req_valid[i] = 1'b0;
                    end else if (!req_valid[i] && $urandom_range(0, 9) == 0) begin
                        req_valid[i] = 1'b1;
                        req_word1[16*i +: 16] = 16'($urandom);
                        req_word2[16*i +: 16] = 16'($urandom);
                    end else if (req_valid[i] && $urandom_range(0, 99) == 0) begin
                        req_valid[i] = 1'b0;
                    end
                end
                #1;
                rel       = c - gstart;
                exp_cs    = !(rel >= 1 && rel <= 32);
                exp_mosi  = (rel >= 1 && rel <= 32) ? gframe[32 - rel] : 1'b0;
                exp_busy  = (rel >= 1 && rel <= 32 + GAP);
                exp_done  = (rel == 33);
                exp_gid   = exp_busy ? 3'(gidx) : 3'd0;
                exp_ready = '0;
                if (rel >= PER && req_valid != '0) begin
                    g = -1;
`ifdef DAC_REQ0_PRIORITY_EN
                    if (req_valid[0]) g = 0;
`endif
                    for (int k = 0; k < N; k++) if (g < 0 && req_valid[(ptr + k) % N]) g = (ptr + k) % N;
                    exp_ready[g] = 1'b1;
                    gstart = c;
                    gidx   = g;
                    gframe = {req_word1[16*g +: 16], req_word2[16*g +: 16]};
`ifdef DAC_REQ0_PRIORITY_EN
                    if (g != 0) ptr = (g + 1) % N;
`else
                    ptr = (g + 1) % N;
`endif
                    ngr++;
                end
                check($sformatf("rand_c%0d", c), {req_ready, DAC_CS, SPI_MOSI, busy, frame_done, grant_id},
                      {exp_ready, exp_cs, exp_mosi, exp_busy, exp_done, exp_gid});
                last_ready = req_ready;
            end
            check("rand_activity", ngr > 20, 1);
            req_valid = '0;
        end

        // GAP_CYCLES=5 instance: CS-high between back-to-back frames
        begin
            int hi, nrun;
            int runs[2];
            bit seen_low;
            @(negedge DAC_CLK);
            reset5 = 1'b0;
            v5 = 4'b0001;
            hi = 0; nrun = 0; seen_low = 0; runs = '{0, 0};
            for (int c = 0; c < 150 && nrun < 2; c++) begin
                @(negedge DAC_CLK);
                #1;
                if (!cs5) begin
                    if (seen_low && hi > 0) begin
                        runs[nrun] = hi;
                        nrun++;
                    end
                    hi = 0;
                    seen_low = 1;
                end else begin
                    hi++;
                end
            end
            check("gap5_runs", nrun, 2);
            check("gap5_high0", runs[0], 6);
            check("gap5_high1", runs[1], 6);
            v5 = '0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
